// File: rtl/sb_hazard_if.sv
// Issue-stage, hazard-source and per-stage control bundle for sb_hazard_unit.
// HAZARD_PERF_CNT_EN adds the three event-counter outputs to the bundle.
interface sb_hazard_if #(
    parameter int NSTAGE = 6,
    parameter int AW     = 5,
    parameter int LATW   = 4
);
    logic              is_valid;
    logic [AW-1:0]     is_rj;
    logic [AW-1:0]     is_rkd;
    logic              is_rj_used;
    logic              is_rkd_used;
    logic [AW-1:0]     is_dest;
    logic              is_dest_we;
    logic [LATW-1:0]   is_lat;
    logic              es_div_busy;
    logic              es_has_ld;
    logic              ms_has_st;
    logic              bp_flush;
    logic              exc_flush;
    logic [NSTAGE-1:0] stall;
    logic [NSTAGE-1:0] flush;
    logic              hazard_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]       perf_raw_cnt;
    logic [31:0]       perf_struct_cnt;
    logic [31:0]       perf_flush_cnt;
`endif

    modport master (
        output is_valid, is_rj, is_rkd, is_rj_used, is_rkd_used, is_dest, is_dest_we, is_lat,
        output es_div_busy, es_has_ld, ms_has_st, bp_flush, exc_flush,
        input  stall, flush, hazard_timeout
`ifdef HAZARD_PERF_CNT_EN
        , input perf_raw_cnt, perf_struct_cnt, perf_flush_cnt
`endif
    );

    modport slave (
        input  is_valid, is_rj, is_rkd, is_rj_used, is_rkd_used, is_dest, is_dest_we, is_lat,
        input  es_div_busy, es_has_ld, ms_has_st, bp_flush, exc_flush,
        output stall, flush, hazard_timeout
`ifdef HAZARD_PERF_CNT_EN
        , output perf_raw_cnt, perf_struct_cnt, perf_flush_cnt
`endif
    );
endinterface

// File: rtl/sb_hazard_unit.sv
// Countdown-scoreboard hazard unit: RAW/WAW interlock, structural freeze, flushes, stall watchdog.
// Build macro HAZARD_PERF_CNT_EN adds 32-bit raw/struct/flush event counters.
module sb_hazard_unit #(
    parameter int NSTAGE      = 6,
    parameter int IS_IDX      = 2,
    parameter int AW          = 5,
    parameter int LATW        = 4,
    parameter int STALL_LIMIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    sb_hazard_if.slave  hif
);
    localparam int          NREG  = 1 << AW;
    localparam logic [31:0] LIMIT = 32'(STALL_LIMIT);

    logic [LATW-1:0]   cnt_q [NREG];
    logic [LATW-1:0]   cnt_d [NREG];
    logic [NSTAGE-1:0] stall_c, flush_c;
    logic              raw, waw, strct, hzd, issue, rec;
    logic [15:0]       wd_q, wd_d;
    logic              timeout_q, timeout_d;

    assign raw   = hif.is_valid & ((hif.is_rj_used  & (cnt_q[hif.is_rj]  != '0)) |
                                   (hif.is_rkd_used & (cnt_q[hif.is_rkd] != '0)));
    assign waw   = hif.is_valid & hif.is_dest_we & (hif.is_dest != '0) &
                   (cnt_q[hif.is_dest] > hif.is_lat);
    assign strct = hif.es_div_busy | (hif.es_has_ld & hif.ms_has_st);
    assign hzd   = raw | waw;

    always_comb begin
        stall_c = '0;
        flush_c = '0;
        if (hif.exc_flush) begin
            flush_c = '1;
        end else if (hif.bp_flush) begin
            for (int i = 0; i < NSTAGE; i++) if (i < IS_IDX) flush_c[i] = 1'b1;
        end else if (strct) begin
            for (int i = 0; i < NSTAGE; i++) if (i <= IS_IDX + 1) stall_c[i] = 1'b1;
            flush_c[IS_IDX+2] = 1'b1;
        end else if (hzd) begin
            for (int i = 0; i < NSTAGE; i++) if (i <= IS_IDX) stall_c[i] = 1'b1;
            flush_c[IS_IDX+1] = 1'b1;
        end
    end

    // A hazarded instruction never issues, even when a bp_flush masks its stall.
    assign issue = hif.is_valid & ~stall_c[IS_IDX] & ~flush_c[IS_IDX] & ~hzd;
    assign rec   = issue & hif.is_dest_we & (hif.is_dest != '0) & (hif.is_lat != '0);

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (hif.exc_flush) begin
                cnt_d[r] = '0;
            end else if (!stall_c[IS_IDX+1]) begin
                if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - LATW'(1);
                if (rec && (hif.is_dest == AW'(r))) cnt_d[r] = hif.is_lat;
            end
            if (r == 0) cnt_d[r] = '0;
        end
    end

    always_comb begin
        wd_d = '0;
        if (|stall_c) wd_d = (wd_q == 16'hFFFF) ? wd_q : wd_q + 16'd1;
        timeout_d = hif.exc_flush ? 1'b0 : (timeout_q | ({16'd0, wd_d} >= LIMIT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign hif.stall          = stall_c;
    assign hif.flush          = flush_c;
    assign hif.hazard_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_raw_q, perf_struct_q, perf_flush_q;
    logic        in_raw_case, in_struct_case;

    assign in_struct_case = ~hif.exc_flush & ~hif.bp_flush & strct;
    assign in_raw_case    = ~hif.exc_flush & ~hif.bp_flush & ~strct & hzd;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_raw_q    <= '0;
            perf_struct_q <= '0;
            perf_flush_q  <= '0;
        end else begin
            if (in_raw_case)                    perf_raw_q    <= perf_raw_q + 32'd1;
            if (in_struct_case)                 perf_struct_q <= perf_struct_q + 32'd1;
            if (hif.exc_flush || hif.bp_flush)  perf_flush_q  <= perf_flush_q + 32'd1;
        end
    end

    assign hif.perf_raw_cnt    = perf_raw_q;
    assign hif.perf_struct_cnt = perf_struct_q;
    assign hif.perf_flush_cnt  = perf_flush_q;
`endif
endmodule
